// File: rtl/line_raster.sv
// Bresenham line rasteriser: accepts one line command, walks it one point per cycle,
// clips off-screen points, applies a dash mask and streams surviving pixels.
module line_raster #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int PAT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic signed [X_W-1:0] x0,
  input  logic signed [X_W-1:0] x1,
  input  logic signed [Y_W-1:0] y0,
  input  logic signed [Y_W-1:0] y1,
  input  logic [COLOUR_W-1:0]   colour,
  input  logic [PAT_W-1:0]      pattern,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [X_W-2:0]        pix_x,
  output logic [Y_W-2:0]        pix_y,
  output logic [COLOUR_W-1:0]   pix_colour,
  output logic                  busy,
  output logic                  done
);

  localparam int E_W   = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic signed [E_W-1:0] ScrW = E_W'(SCREEN_W);
  localparam logic signed [E_W-1:0] ScrH = E_W'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic signed [X_W-1:0] r_cx, r_x1;
  logic signed [Y_W-1:0] r_cy, r_y1;
  logic signed [E_W-1:0] r_dx, r_dy, r_err;
  logic                  r_sx_neg, r_sy_neg;
  logic [IDX_W-1:0]      r_idx;
  logic [COLOUR_W-1:0]   r_colour;
  logic [PAT_W-1:0]      r_pattern;

  // Command setup, all in E_W so |x1-x0| and -|y1-y0| cannot overflow.
  logic signed [E_W-1:0] w_x0e, w_x1e, w_y0e, w_y1e;
  logic signed [E_W-1:0] w_ddx, w_ddy, w_dx_abs, w_dy_neg;

  assign w_x0e    = {{(E_W-X_W){x0[X_W-1]}}, x0};
  assign w_x1e    = {{(E_W-X_W){x1[X_W-1]}}, x1};
  assign w_y0e    = {{(E_W-Y_W){y0[Y_W-1]}}, y0};
  assign w_y1e    = {{(E_W-Y_W){y1[Y_W-1]}}, y1};
  assign w_ddx    = w_x1e - w_x0e;
  assign w_ddy    = w_y1e - w_y0e;
  assign w_dx_abs = w_ddx[E_W-1] ? -w_ddx : w_ddx;
  assign w_dy_neg = w_ddy[E_W-1] ? w_ddy : -w_ddy;

  // Per-point evaluation
  logic signed [E_W-1:0] w_cxe, w_cye;
  logic                  w_on_screen, w_emit, w_step, w_at_end;
  logic signed [E_W:0]   w_e2, w_dx_x, w_dy_x;
  logic                  w_mv_x, w_mv_y;
  logic signed [E_W-1:0] w_err_next;

  assign w_cxe       = {{(E_W-X_W){r_cx[X_W-1]}}, r_cx};
  assign w_cye       = {{(E_W-Y_W){r_cy[Y_W-1]}}, r_cy};
  assign w_on_screen = !w_cxe[E_W-1] && (w_cxe < ScrW) && !w_cye[E_W-1] && (w_cye < ScrH);
  assign w_emit      = (r_state == StDraw) && w_on_screen && r_pattern[r_idx];
  assign w_step      = (r_state == StDraw) && (!w_emit || pix_ready);
  assign w_at_end    = (r_cx == r_x1) && (r_cy == r_y1);

  assign w_e2       = {r_err, 1'b0};
  assign w_dx_x     = {r_dx[E_W-1], r_dx};
  assign w_dy_x     = {r_dy[E_W-1], r_dy};
  assign w_mv_x     = (w_e2 >= w_dy_x);
  assign w_mv_y     = (w_e2 <= w_dx_x);
  assign w_err_next = r_err + (w_mv_x ? r_dy : '0) + (w_mv_y ? r_dx : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    start_ready  = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) w_state_next = StDraw;
      end
      StDraw: begin
        if (w_step && w_at_end) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cx      <= '0;
      r_cy      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_err     <= '0;
      r_sx_neg  <= 1'b0;
      r_sy_neg  <= 1'b0;
      r_idx     <= '0;
      r_colour  <= '0;
      r_pattern <= '0;
    end else if (r_state == StIdle && start_valid) begin
      r_cx      <= x0;
      r_cy      <= y0;
      r_x1      <= x1;
      r_y1      <= y1;
      r_dx      <= w_dx_abs;
      r_dy      <= w_dy_neg;
      r_err     <= w_dx_abs + w_dy_neg;
      r_sx_neg  <= !(x0 < x1);
      r_sy_neg  <= !(y0 < y1);
      r_idx     <= '0;
      r_colour  <= colour;
      r_pattern <= pattern;
    end else if (w_step && !w_at_end) begin
      r_err <= w_err_next;
      if (w_mv_x) r_cx <= r_sx_neg ? r_cx - X_W'(1) : r_cx + X_W'(1);
      if (w_mv_y) r_cy <= r_sy_neg ? r_cy - Y_W'(1) : r_cy + Y_W'(1);
      r_idx <= (r_idx == IDX_W'(PAT_W - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign busy       = (r_state != StIdle);
  assign pix_valid  = w_emit;
  assign pix_x      = r_cx[X_W-2:0];
  assign pix_y      = r_cy[Y_W-2:0];
  assign pix_colour = r_colour;

endmodule
